// File: rtl/branch_ctrl.sv
// Branch resolution and prediction control: a 2-bit bimodal BHT, mispredict redirect/flush,
// a one-cycle RECOVER state that ignores the squashed EX occupant, and branch statistics.
module branch_ctrl #(
    parameter int BHT_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    output logic        id_pred_taken,
    input  logic        ex_valid,
    input  logic [2:0]  ex_br_type,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic        ex_stall,
    output logic [2:0]  cmp_type,
    input  logic        cmp_bre,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic [31:0] br_count,
    output logic [31:0] mis_count
);

    localparam int BHT_SIZE = 1 << BHT_IDX_W;

    typedef enum logic {
        RUN,
        RECOVER
    } state_t;

    state_t                 state, state_next;
    logic [1:0]             bht [BHT_SIZE];
    logic                   resolved_flag;
    logic                   ex_branch;
    logic                   resolve;
    logic                   mispredict;
    logic [BHT_IDX_W-1:0]   id_idx;
    logic [BHT_IDX_W-1:0]   ex_idx;

    assign id_idx = id_pc[BHT_IDX_W+1:2];
    assign ex_idx = ex_pc[BHT_IDX_W+1:2];

    // Reads the table before this cycle's update lands, so ID sees the pre-update value.
    assign id_pred_taken = id_valid & bht[id_idx][1];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        cmp_type    = 3'b000;
        ex_branch   = 1'b0;
        resolve     = 1'b0;
        mispredict  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        state_next  = state;

        if (ex_valid) cmp_type = ex_br_type;
        ex_branch = ex_valid && (ex_br_type[2:1] != 2'b00);
        resolve   = ex_branch && !ex_stall && (state == RUN) && !resolved_flag && !rst;
        mispredict = resolve && (cmp_bre != ex_pred_taken);

        if (mispredict) begin
            redirect    = 1'b1;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            redirect_pc = cmp_bre ? ex_target : ex_pc + 32'd4;
        end

        unique case (state)
            RUN:     if (mispredict) state_next = RECOVER;
            RECOVER: state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            resolved_flag <= 1'b0;
            br_count      <= 32'h0;
            mis_count     <= 32'h0;
        end else begin
            state <= state_next;
            if (!ex_stall)    resolved_flag <= 1'b0;
            else if (resolve) resolved_flag <= 1'b1;
            if (resolve)    br_count  <= br_count + 32'd1;
            if (mispredict) mis_count <= mis_count + 32'd1;
        end
    end

    // NOTE: the BHT is a small flop array, not a RAM, so it can and must be reset to weak-NT.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
        end else if (resolve) begin
            if (cmp_bre && bht[ex_idx] != 2'b11)
                bht[ex_idx] <= bht[ex_idx] + 2'd1;
            else if (!cmp_bre && bht[ex_idx] != 2'b00)
                bht[ex_idx] <= bht[ex_idx] - 2'd1;
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: prediction, training, redirect/flush, recovery,
// stall deferral, address wrap and reset priority, with hand-computed expectations.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic        ex_valid;
    logic [2:0]  ex_br_type;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        ex_stall;
    logic [2:0]  cmp_type;
    logic        cmp_bre;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_ifid;
    logic        flush_idex;
    logic [31:0] br_count;
    logic [31:0] mis_count;

    int n_checks = 0;
    int n_fail   = 0;

    branch_ctrl #(.BHT_IDX_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
        .ex_valid(ex_valid), .ex_br_type(ex_br_type), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_stall(ex_stall),
        .cmp_type(cmp_type), .cmp_bre(cmp_bre),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .br_count(br_count), .mis_count(mis_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic set_ex(input logic v, input logic [2:0] t, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic pred, input logic bre,
                          input logic stall);
        ex_valid = v; ex_br_type = t; ex_pc = pc; ex_target = tgt;
        ex_pred_taken = pred; cmp_bre = bre; ex_stall = stall;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_redir(input string tag, input logic r, input logic [31:0] rpc);
        check({tag, "_redirect"}, {31'h0, redirect}, {31'h0, r});
        check({tag, "_redirect_pc"}, redirect_pc, rpc);
        check({tag, "_flush"}, {30'h0, flush_ifid, flush_idex}, {30'h0, r, r});
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_pc = 32'h0;
        set_ex(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;

        // Reset state and initial weak-NT prediction.
        check("rst_br_count", br_count, 32'd0);
        check("rst_mis_count", mis_count, 32'd0);
        check("rst_bht0", {30'h0, dut.bht[0]}, 32'd1);
        id_valid = 1'b1; id_pc = 32'h100; #1;
        check("rst_pred", {31'h0, id_pred_taken}, 32'd0);
        check("cmp_type_idle", {29'h0, cmp_type}, 32'd0);

        // BEQ mispredicted not-taken, actually taken.
        set_ex(1'b1, 3'b010, 32'h100, 32'h80, 1'b0, 1'b1, 1'b0);
        check("beq_cmp_type", {29'h0, cmp_type}, 32'd2);
        check_redir("beq_mis", 1'b1, 32'h80);
        tick();
        check("beq_bht0", {30'h0, dut.bht[0]}, 32'd2);
        check("beq_br_count", br_count, 32'd1);
        check("beq_mis_count", mis_count, 32'd1);
        check("beq_pred_after", {31'h0, id_pred_taken}, 32'd1);
        // RECOVER: same EX occupant ignored.
        check_redir("recover", 1'b0, 32'h0);
        tick();
        check("recover_br_count", br_count, 32'd1);
        check("recover_bht0", {30'h0, dut.bht[0]}, 32'd2);

        // Three correct taken resolutions: 10 -> 11 -> 11 -> 11.
        set_ex(1'b1, 3'b010, 32'h100, 32'h80, 1'b1, 1'b1, 1'b0);
        check_redir("correct_taken", 1'b0, 32'h0);
        tick();
        check("sat_bht0_a", {30'h0, dut.bht[0]}, 32'd3);
        tick();
        tick();
        check("sat_bht0_b", {30'h0, dut.bht[0]}, 32'd3);
        check("sat_br_count", br_count, 32'd4);
        check("sat_mis_count", mis_count, 32'd1);

        // Index 1: train to 10, then same-cycle ID read with decrement back to 01.
        id_pc = 32'h104;
        set_ex(1'b1, 3'b100, 32'h104, 32'h200, 1'b0, 1'b1, 1'b0);
        check_redir("blt_mis_taken", 1'b1, 32'h200);
        tick();
        set_ex(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        set_ex(1'b1, 3'b100, 32'h104, 32'h200, 1'b1, 1'b0, 1'b0);
        check("bypass_pred_pre", {31'h0, id_pred_taken}, 32'd1);
        check_redir("blt_mis_nt", 1'b1, 32'h108);
        tick();
        check("bypass_bht1", {30'h0, dut.bht[1]}, 32'd1);
        check("bypass_pred_post", {31'h0, id_pred_taken}, 32'd0);
        check("bypass_counts", {br_count[15:0], mis_count[15:0]}, {16'd6, 16'd3});
        set_ex(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();

        // BNE at the top of the address space: fall-through wraps to 0.
        set_ex(1'b1, 3'b011, 32'hFFFF_FFFC, 32'h40, 1'b1, 1'b0, 1'b0);
        check_redir("bne_wrap", 1'b1, 32'h0);
        tick();
        check("bne_bht15", {30'h0, dut.bht[15]}, 32'd0);
        set_ex(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();

        // BGE held three cycles, then released: resolved exactly once.
        set_ex(1'b1, 3'b101, 32'h108, 32'h300, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_redir("stall_hold", 1'b0, 32'h0);
            tick();
        end
        check("stall_br_count_held", br_count, 32'd7);
        set_ex(1'b1, 3'b101, 32'h108, 32'h300, 1'b1, 1'b0, 1'b0);
        check_redir("stall_release", 1'b1, 32'h10C);
        tick();
        check("stall_br_count", br_count, 32'd8);
        check("stall_mis_count", mis_count, 32'd5);
        check("stall_bht2", {30'h0, dut.bht[2]}, 32'd0);
        set_ex(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();

        // Non-branch types never resolve; cmp_type masked when EX invalid.
        set_ex(1'b1, 3'b001, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        check("nonbr_cmp_type", {29'h0, cmp_type}, 32'd1);
        check_redir("nonbr", 1'b0, 32'h0);
        tick();
        set_ex(1'b0, 3'b110, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        check("invalid_cmp_type", {29'h0, cmp_type}, 32'd0);
        tick();
        check("nonbr_br_count", br_count, 32'd8);

        // Mispredict coinciding with reset is discarded.
        rst = 1'b1;
        set_ex(1'b1, 3'b111, 32'h100, 32'h500, 1'b0, 1'b1, 1'b0);
        check_redir("rst_mis", 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        set_ex(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("rst2_counts", {br_count[15:0], mis_count[15:0]}, 32'd0);
        check("rst2_bht0", {30'h0, dut.bht[0]}, 32'd1);
        check("rst2_bht15", {30'h0, dut.bht[15]}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL have parameter BHT_IDX_W, default 4, meaning log2 of the number of branch-history entries (16 entries).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port id_valid, input, 1 bit: a conditional branch is in ID requesting a prediction.
REQ-005 The block SHALL have port id_pc, input, 32 bits: PC of the ID-stage instruction.
REQ-006 The block SHALL have port id_pred_taken, output, 1 bit: prediction for the ID branch.
REQ-007 The block SHALL have port ex_valid, input, 1 bit: the EX-stage instruction is valid.
REQ-008 The block SHALL have port ex_br_type, input, 3 bits: branch type in EX, with encodings 010 BEQ, 011 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 000 and 001 mean not a branch.
REQ-009 The block SHALL have port ex_pc, input, 32 bits: PC of the EX instruction.
REQ-010 The block SHALL have port ex_target, input, 32 bits: computed taken target.
REQ-011 The block SHALL have port ex_pred_taken, input, 1 bit: the prediction carried down the pipe with the EX instruction.
REQ-012 The block SHALL have port ex_stall, input, 1 bit: EX is held this cycle.
REQ-013 The block SHALL have port cmp_type, output, 3 bits: type driven to the branch comparator.
REQ-014 The block SHALL have port cmp_bre, input, 1 bit: comparator result, taken=1.
REQ-015 The block SHALL have port redirect, output, 1 bit: load redirect_pc into the PC.
REQ-016 The block SHALL have port redirect_pc, output, 32 bits: PC to fetch from after a mispredict.
REQ-017 The block SHALL have port flush_ifid, output, 1 bit: squash IF/ID.
REQ-018 The block SHALL have port flush_idex, output, 1 bit: squash ID/EX.
REQ-019 The block SHALL have port br_count, output, 32 bits: number of resolved branches.
REQ-020 The block SHALL have port mis_count, output, 32 bits: number of mispredicts.

Function
REQ-021 cmp_type SHALL equal ex_br_type when ex_valid=1, and 000 otherwise (combinational).
REQ-022 An EX branch SHALL be defined as ex_valid=1 with ex_br_type[2:1] != 00.
REQ-023 The block SHALL hold 2^BHT_IDX_W two-bit saturating counters indexed by pc[BHT_IDX_W+1:2], with states 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-024 id_pred_taken SHALL be the combinational bit[1] of counter[id_pc index] AND id_valid.
REQ-025 Resolution SHALL occur in a cycle when an EX branch is present, ex_stall=0, the FSM is in RUN, and resolved_flag=0.
REQ-026 On resolution, counter[ex_pc index] SHALL increment (saturating at 11) if cmp_bre=1, or decrement (saturating at 00) if cmp_bre=0, in the same clock edge.
REQ-027 On resolution, br_count SHALL increment by 1; on mispredict (cmp_bre != ex_pred_taken), mis_count SHALL also increment; both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 On mispredict, redirect, flush_ifid and flush_idex SHALL be 1 combinationally in the resolving cycle.
REQ-029 On mispredict, redirect_pc SHALL be ex_target if cmp_bre=1, else ex_pc+4 (mod 2^32); redirect_pc SHALL be 0 when redirect=0.
REQ-030 The FSM SHALL have two states, RUN and RECOVER; a mispredict SHALL move RUN→RECOVER, and RECOVER SHALL return to RUN after exactly 1 cycle.
REQ-031 In RECOVER, no resolution, counter update or redirect SHALL occur; the squashed EX occupant is ignored.
REQ-032 resolved_flag SHALL be set when a resolution happens while the next cycle keeps the same EX occupant (ex_stall=1 in the following cycles), and cleared when ex_stall=0; a stalled branch SHALL be counted and trained exactly once.
REQ-033 If ex_stall=1 in the first cycle a branch reaches EX, resolution SHALL be deferred to the first cycle with ex_stall=0.
REQ-034 When the same index is read by ID and updated by EX in one cycle, id_pred_taken SHALL use the pre-update value.
REQ-035 Correct predictions SHALL cause no redirect and no flush.

Reset
REQ-036 On rst=1 at a clock edge: FSM=RUN, resolved_flag=0, all BHT counters=01, br_count=0, mis_count=0.
REQ-037 While rst=1, redirect, flush_ifid and flush_idex SHALL be forced to 0; a branch resolving mid-reset SHALL be discarded.

Verification
REQ-038 Scenario: after reset, id_valid=1, id_pc=0x100 → id_pred_taken=0.
REQ-039 Scenario: BEQ at ex_pc=0x100, pred 0, cmp_bre=1, ex_target=0x80 → redirect=1, redirect_pc=0x80, both flushes=1, counter[0]=10, br_count=1, mis_count=1; next cycle redirect=0 with EX ignored.
REQ-040 Scenario: same branch resolved taken twice more → counter=11; a fourth taken resolution leaves it at 11.
REQ-041 Scenario: BNE, pred 1, cmp_bre=0, ex_pc=0xFFFFFFFC → redirect_pc=0x00000000.
REQ-042 Scenario: branch held 3 cycles with ex_stall=1, then released → br_count increments by exactly 1.
REQ-043 Scenario: mispredict in the same cycle as rst=1 → no redirect, counters=0, BHT=01.
